// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The entry layout fixes the address/data widths; instantiate the fetch
// unit with ADDR_W/DATA_W equal to IFU_ADDR_W/IFU_DATA_W.
package ifu_pkg;

    localparam int IFU_ADDR_W = 32;
    localparam int IFU_DATA_W = 32;
    localparam int PC_STEP    = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0] pc;
        logic [IFU_DATA_W-1:0] data;
        logic                  filled;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_queue.sv
// In-order fetch queue. Entries are allocated at request time (pc known,
// data pending), filled when the matching response returns, and retired by
// decode. Pointers carry one extra wrap bit so that full and empty differ.
module ifu_queue
    import ifu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc,
    input  logic [IFU_ADDR_W-1:0] alloc_pc,
    input  logic                  fill,
    input  logic [IFU_DATA_W-1:0] fill_data,
    input  logic                  retire,
    output ifu_entry_t            head,
    output logic [PW-1:0]         q_count,
    output logic [PW-1:0]         unfilled
);

    localparam int IW = PW - 1;

    ifu_entry_t    mem_q [DEPTH];
    logic [PW-1:0] alloc_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] read_ptr;

    // Pointer advance; a flush returns every pointer to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            read_ptr  <= '0;
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            read_ptr  <= '0;
        end else begin
            if (alloc)  alloc_ptr <= alloc_ptr + PW'(1);
            if (fill)   fill_ptr  <= fill_ptr + PW'(1);
            if (retire) read_ptr  <= read_ptr + PW'(1);
        end
    end

    // Entry storage; alloc and fill never target the same slot in one cycle
    // because a fill needs an older unfilled entry ahead of the alloc slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush) begin
            if (alloc) begin
                mem_q[alloc_ptr[IW-1:0]].pc     <= alloc_pc;
                mem_q[alloc_ptr[IW-1:0]].data   <= '0;
                mem_q[alloc_ptr[IW-1:0]].filled <= 1'b0;
            end
            if (fill) begin
                mem_q[fill_ptr[IW-1:0]].data   <= fill_data;
                mem_q[fill_ptr[IW-1:0]].filled <= 1'b1;
            end
        end
    end

    assign head     = mem_q[read_ptr[IW-1:0]];
    assign q_count  = alloc_ptr - read_ptr;
    assign unfilled = alloc_ptr - fill_ptr;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: next-PC selection, credit-limited in-order
// memory requests, response buffering and redirect handling. After a
// redirect, responses still in flight for flushed entries are counted
// down in DRAIN and discarded.
// Optional build macro IFU_PERF_EN adds saturating stall/flush counters.
//
// state | meaning
// RUN   | normal fetch; requests issued while credit is available
// DRAIN | discarding stale responses left over from a redirect
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter  int ADDR_W = IFU_ADDR_W,
    parameter  int DATA_W = IFU_DATA_W,
    parameter  int DEPTH  = 4,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_address,
    output logic [ADDR_W-1:0] next_address,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic [CW-1:0]     q_count
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flushes
`endif
);

    ifu_state_e    state_q, state_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] unfilled;
    ifu_entry_t    head;
    logic          req_fire;
    logic          dec_fire;
    logic          fill_en;

    // Requests and instr_valid are forced low while reset is held.
    assign imem_req_valid = rst && (state_q == RUN) && !redirect_valid
                            && (q_count < CW'(DEPTH));
    assign imem_req_addr  = pc_address;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = rst && (q_count != '0) && head.filled;
    assign instr_data  = head.data;
    assign instr_pc    = head.pc;
    assign dec_fire    = instr_valid && instr_ready;

    // Responses only land in the queue when they belong to live entries.
    assign fill_en = imem_rsp_valid && (state_q == RUN) && !redirect_valid;

    ifu_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .alloc     (req_fire),
        .alloc_pc  (pc_address),
        .fill      (fill_en),
        .fill_data (imem_rsp_data),
        .retire    (dec_fire),
        .head      (head),
        .q_count   (q_count),
        .unfilled  (unfilled)
    );

    // Next PC: redirect wins, then sequential step on a request fire, else hold.
    always_comb begin
        next_address = pc_address;
        if (redirect_valid) begin
            next_address = redirect_target;
        end else if (req_fire) begin
            next_address = pc_address + ADDR_W'(PC_STEP);
        end
    end

    // Drain bookkeeping: a response arriving in the redirect cycle is already
    // accounted for, so it is subtracted from the outstanding count.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    drop_d  = unfilled - CW'(imem_rsp_valid && (unfilled != '0));
                    state_d = (drop_d != '0) ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    drop_d = drop_q - CW'(1);
                    if (drop_q == CW'(1)) state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                drop_d  = '0;
            end
        endcase
    end

    // State and drop counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // A response in RUN must have an outstanding request to fill.
    rsp_has_owner_a: assert property (@(posedge clk) disable iff (!rst)
        (imem_rsp_valid && (state_q == RUN)) |-> (unfilled != '0));

`ifdef IFU_PERF_EN
    // Saturating counters for decode starvation and redirects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (instr_ready && !instr_valid && (perf_stall_cycles != 32'hFFFF_FFFF))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (redirect_valid && (perf_flushes != 32'hFFFF_FFFF))
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit. The reference model tracks the
// fetch stream at transaction level: the next expected decode PC, how many
// entries and filled entries the queue should hold, and how many stale
// responses remain after a redirect. The bench also acts as PC register
// and as an in-order instruction memory with configurable latency.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam logic [31:0] NO_TGT = 32'h0000_0001;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] pc_address;
    logic [ADDR_W-1:0] next_address;
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic [CW-1:0]     q_count;
`ifdef IFU_PERF_EN
    logic [31:0]       perf_stall_cycles;
    logic [31:0]       perf_flushes;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_address      (pc_address),
        .next_address    (next_address),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .q_count         (q_count)
`ifdef IFU_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
`endif
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pend[$];
    int unsigned cyc;
    logic [31:0] pc_q;
    logic [31:0] m_exp_pc;
    int          m_count;
    int          m_filled;
    int          m_stale;

    // One clock cycle: drive inputs, check outputs against the model at the
    // negedge, then advance the model and the PC register across the posedge.
    task automatic cycle_run(input int p_rdy, input int p_irdy, input int p_redir,
                             input int lat_min, input int lat_max, input logic [31:0] tgt_fix);
        logic        rsp;
        logic [31:0] tgt;
        logic [31:0] pc_next;
        logic [31:0] rsp_addr;
        bit          exp_rv, exp_iv, req_fire, dec_fire;
        int          lat;

        imem_req_ready = ($urandom_range(99) < p_rdy);
        instr_ready    = ($urandom_range(99) < p_irdy);
        redirect_valid = ($urandom_range(99) < p_redir);
        tgt = (tgt_fix == NO_TGT) ? ($urandom & 32'hFFFF_FFFC) : tgt_fix;
        redirect_target = tgt;
        rsp = (pend.size() > 0) && (pend[0].due <= cyc);
        rsp_addr = rsp ? pend[0].addr : 32'h0;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(rsp_addr) : $urandom;

        @(negedge clk);
        exp_rv = (m_stale == 0) && !redirect_valid && (m_count < DEPTH);
        exp_iv = (m_filled > 0);
        check("req_valid", imem_req_valid, exp_rv);
        check("instr_valid", instr_valid, exp_iv);
        check("q_count", q_count, m_count);
        if (exp_rv) check("req_addr", imem_req_addr, pc_q);
        if (exp_iv) begin
            check("instr_pc", instr_pc, m_exp_pc);
            check("instr_data", instr_data, mem_word(m_exp_pc));
        end

        req_fire = exp_rv && imem_req_ready;
        dec_fire = exp_iv && instr_ready;
        if (redirect_valid)  pc_next = tgt;
        else if (req_fire)   pc_next = pc_q + 32'd4;
        else                 pc_next = pc_q;
        check("next_address", next_address, pc_next);

        if (rsp) void'(pend.pop_front());
        if (req_fire) begin
            lat = $urandom_range(lat_max, lat_min);
            pend.push_back('{addr: pc_q, due: cyc + lat});
        end
        if (redirect_valid) begin
            m_count  = 0;
            m_filled = 0;
            m_stale  = pend.size();
            m_exp_pc = tgt;
        end else begin
            if (rsp) begin
                if (m_stale > 0) m_stale--;
                else             m_filled++;
            end
            m_count  = m_count + int'(req_fire) - int'(dec_fire);
            m_filled = m_filled - int'(dec_fire);
            if (dec_fire) m_exp_pc = m_exp_pc + 32'd4;
        end

        @(posedge clk);
        #1;
        cyc++;
        pc_q       = pc_next;
        pc_address = pc_q;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop at once.
    task automatic reset_mid();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("arst_req_valid", imem_req_valid, 1'b0);
        check("arst_instr_valid", instr_valid, 1'b0);
        check("arst_q_count", q_count, 0);
        @(posedge clk);
        #1;
        check("arst_hold_q_count", q_count, 0);
        pend.delete();
        m_count    = 0;
        m_filled   = 0;
        m_stale    = 0;
        pc_q       = 32'h0000_0200;
        pc_address = pc_q;
        m_exp_pc   = pc_q;
        rst = 1'b1;
        cyc++;
    endtask

    initial begin
        pc_q            = 32'h0;
        pc_address      = 32'h0;
        m_exp_pc        = 32'h0;
        m_count         = 0;
        m_filled        = 0;
        m_stale         = 0;
        cyc             = 0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        instr_ready     = 1'b1;

        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_q_count", q_count, 0);
        check("rst_instr_data", instr_data, 0);
        check("rst_instr_pc", instr_pc, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Steady stream, 1-cycle memory.
        repeat (20) cycle_run(100, 100, 0, 1, 1, NO_TGT);
        // Decode stalled: queue fills to DEPTH and requests stop.
        repeat (10) cycle_run(100, 0, 0, 1, 1, NO_TGT);
        check("full_q_count", q_count, DEPTH);
        repeat (12) cycle_run(100, 100, 0, 1, 1, NO_TGT);
        // Slow memory with requests outstanding, then redirect to 0x100.
        repeat (2) cycle_run(100, 0, 0, 3, 3, NO_TGT);
        cycle_run(100, 100, 100, 3, 3, 32'h0000_0100);
        repeat (15) cycle_run(100, 100, 0, 3, 3, NO_TGT);
        // Address wrap at the top of the space.
        cycle_run(100, 100, 100, 1, 1, 32'hFFFF_FFFC);
        repeat (10) cycle_run(100, 100, 0, 1, 1, NO_TGT);
        // Random traffic including redirects coinciding with responses/decode.
        repeat (1500) cycle_run(70, 60, 6, 1, 4, NO_TGT);
        // Build up outstanding requests, redirect into DRAIN, then reset.
        repeat (3) cycle_run(100, 100, 0, 5, 5, NO_TGT);
        cycle_run(100, 100, 100, 5, 5, 32'h0000_0040);
        reset_mid();
        repeat (20) cycle_run(100, 100, 0, 1, 2, NO_TGT);
        repeat (1500) cycle_run(80, 80, 4, 1, 3, NO_TGT);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
